wb_write_arbiter: RTL and testbench

//  Writer side of the 2-write-port physical register file. Collects completed results (pdest, value)

---
 rtl/wb_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: collects completed FU results through a round-robin
// arbiter into an in-order FIFO. Up to two entries per cycle drain onto the
// two physical regfile write ports. Back-to-back writes to the same pdest are
// split over two cycles so that the later write always lands last.
module wb_write_arbiter #(
    parameter  int XLEN        = 64,
    parameter  int PREG_NUMBER = 64,
    parameter  int NUM_FU      = 4,
    parameter  int DEPTH       = 8,
    localparam int IDXW        = $clog2(PREG_NUMBER),
    localparam int CNTW        = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*IDXW-1:0]   fu_pdest,
    input  logic [NUM_FU*XLEN-1:0]   fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic                     wb_hold,
    output logic                     wra_en,
    output logic [IDXW-1:0]          wra_idx,
    output logic [XLEN-1:0]          wra_data,
    output logic                     wrb_en,
    output logic [IDXW-1:0]          wrb_idx,
    output logic [XLEN-1:0]          wrb_data,
    output logic [CNTW-1:0]          fifo_cnt
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int RRW  = $clog2(NUM_FU);

    logic [IDXW-1:0] pdest_q [DEPTH];
    logic [IDXW-1:0] pdest_d [DEPTH];
    logic [XLEN-1:0] data_q  [DEPTH];
    logic [XLEN-1:0] data_d  [DEPTH];
    logic [PTRW-1:0] head_q, head_d, tail_q, tail_d, head1_s;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RRW-1:0]  rr_q, rr_d;

    logic [NUM_FU-1:0] ready_s;
    logic [1:0]        max_g_s, n_grant_s, pop_s;
    logic [RRW-1:0]    idx_s, first_s, second_s, last_s;
    logic              take_s, a_en_s, b_en_s;

    // Round-robin grant of up to two FUs, limited by free slots (no drain credit).
    always_comb begin
        ready_s   = '0;
        n_grant_s = 2'd0;
        first_s   = '0;
        second_s  = '0;
        last_s    = rr_q;
        idx_s     = rr_q;
        take_s    = 1'b0;
        if (cnt_q == CNTW'(DEPTH)) begin
            max_g_s = 2'd0;
        end else if (cnt_q == CNTW'(DEPTH - 1)) begin
            max_g_s = 2'd1;
        end else begin
            max_g_s = 2'd2;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            idx_s          = RRW'((int'(rr_q) + k) % NUM_FU);
            take_s         = fu_valid[idx_s] && (n_grant_s < max_g_s);
            ready_s[idx_s] = ready_s[idx_s] | take_s;
            first_s        = (take_s && (n_grant_s == 2'd0)) ? idx_s : first_s;
            second_s       = (take_s && (n_grant_s == 2'd1)) ? idx_s : second_s;
            last_s         = take_s ? idx_s : last_s;
            n_grant_s      = n_grant_s + {1'b0, take_s};
        end
    end

    // Drain decision: A takes the head, B takes head+1 unless it targets the same pdest.
    always_comb begin
        head1_s = head_q + PTRW'(1);
        a_en_s  = !wb_hold && (cnt_q != CNTW'(0));
        b_en_s  = !wb_hold && (cnt_q >= CNTW'(2)) && (pdest_q[head1_s] != pdest_q[head_q]);
        pop_s   = {1'b0, a_en_s} + {1'b0, b_en_s};
    end

    // Write-port outputs, forced to zero whenever the matching enable is low.
    always_comb begin
        fu_ready = ready_s;
        fifo_cnt = cnt_q;
        wra_en   = a_en_s;
        wrb_en   = b_en_s;
        if (a_en_s) begin
            wra_idx  = pdest_q[head_q];
            wra_data = data_q[head_q];
        end else begin
            wra_idx  = '0;
            wra_data = '0;
        end
        if (b_en_s) begin
            wrb_idx  = pdest_q[head1_s];
            wrb_data = data_q[head1_s];
        end else begin
            wrb_idx  = '0;
            wrb_data = '0;
        end
    end

    // Next-state: enqueue granted results in order, advance pointers and arbiter.
    always_comb begin
        pdest_d = pdest_q;
        data_d  = data_q;
        if (n_grant_s != 2'd0) begin
            pdest_d[tail_q] = fu_pdest[int'(first_s)*IDXW +: IDXW];
            data_d[tail_q]  = fu_data[int'(first_s)*XLEN +: XLEN];
            rr_d            = RRW'((int'(last_s) + 1) % NUM_FU);
        end else begin
            rr_d = rr_q;
        end
        if (n_grant_s == 2'd2) begin
            pdest_d[tail_q + PTRW'(1)] = fu_pdest[int'(second_s)*IDXW +: IDXW];
            data_d[tail_q + PTRW'(1)]  = fu_data[int'(second_s)*XLEN +: XLEN];
        end else begin
            pdest_d[tail_q + PTRW'(1)] = pdest_d[tail_q + PTRW'(1)];
        end
        tail_d = tail_q + PTRW'(n_grant_s);
        head_d = head_q + PTRW'(pop_s);
        cnt_d  = cnt_q + CNTW'(n_grant_s) - CNTW'(pop_s);
    end

    // State registers with synchronous reset that discards all buffered entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            rr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pdest_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            pdest_q <= pdest_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: accepted results are queued in
// arbitration order and compared against the write ports as they drain.
module tb_wb_write_arbiter;

    localparam int XLEN  = 64;
    localparam int NF    = 4;
    localparam int DEPTH = 8;
    localparam int IDXW  = 6;

    typedef struct packed {
        logic [IDXW-1:0] p;
        logic [XLEN-1:0] d;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NF-1:0]        fu_valid = '0;
    logic [NF*IDXW-1:0]   fu_pdest = '0;
    logic [NF*XLEN-1:0]   fu_data = '0;
    logic [NF-1:0]        fu_ready;
    logic                 wb_hold = 1'b0;
    logic                 wra_en, wrb_en;
    logic [IDXW-1:0]      wra_idx, wrb_idx;
    logic [XLEN-1:0]      wra_data, wrb_data;
    logic [3:0]           fifo_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_rr  = 0;
    int   seq   = 0;
    ent_t sbq[$];

    wb_write_arbiter #(.XLEN(XLEN), .PREG_NUMBER(64), .NUM_FU(NF), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .fu_valid(fu_valid), .fu_pdest(fu_pdest),
        .fu_data(fu_data), .fu_ready(fu_ready), .wb_hold(wb_hold),
        .wra_en(wra_en), .wra_idx(wra_idx), .wra_data(wra_data),
        .wrb_en(wrb_en), .wrb_idx(wrb_idx), .wrb_data(wrb_data),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: pdests unique across adjacent cycles; mode 1: small random range to force collisions
    task automatic load_fu(input int mode);
        for (int i = 0; i < NF; i++) begin
            fu_pdest[i*IDXW +: IDXW] = (mode == 0) ? IDXW'((seq*4 + i) % 64) : IDXW'($urandom_range(0, 7));
            fu_data[i*XLEN +: XLEN]  = {$urandom, $urandom};
        end
        seq++;
    endtask

    // One cycle: drive at negedge, check outputs against the scoreboard, update it at posedge.
    task automatic step(input logic [NF-1:0] v, input logic h, input logic r);
        logic [NF-1:0] er;
        int   ord[2];
        int   g, mg, idx, sz;
        logic ea, eb;
        ent_t e0, e1, ne;
        fu_valid = v;
        wb_hold  = h;
        reset    = r;
        #1;
        sz = sbq.size();
        mg = DEPTH - sz;
        if (mg > 2) mg = 2;
        g  = 0;
        er = '0;
        ord[0] = 0;
        ord[1] = 0;
        for (int k = 0; k < NF; k++) begin
            idx = (m_rr + k) % NF;
            if (v[idx] && g < mg) begin
                er[idx] = 1'b1;
                ord[g]  = idx;
                g++;
            end
        end
        e0 = '0;
        e1 = '0;
        if (sz >= 1) e0 = sbq[0];
        if (sz >= 2) e1 = sbq[1];
        ea = !h && (sz >= 1);
        eb = !h && (sz >= 2) && (e1.p != e0.p);
        check_val("fu_ready", 64'(fu_ready), 64'(er));
        check_val("fifo_cnt", 64'(fifo_cnt), 64'(sz));
        check_val("wra_en",   64'(wra_en), 64'(ea));
        check_val("wra_idx",  64'(wra_idx), ea ? 64'(e0.p) : 64'd0);
        check_val("wra_data", wra_data, ea ? e0.d : 64'd0);
        check_val("wrb_en",   64'(wrb_en), 64'(eb));
        check_val("wrb_idx",  64'(wrb_idx), eb ? 64'(e1.p) : 64'd0);
        check_val("wrb_data", wrb_data, eb ? e1.d : 64'd0);
        @(posedge clk);
        if (r) begin
            sbq.delete();
            m_rr = 0;
        end else begin
            if (ea) void'(sbq.pop_front());
            if (eb) void'(sbq.pop_front());
            for (int j = 0; j < g; j++) begin
                ne.p = fu_pdest[ord[j]*IDXW +: IDXW];
                ne.d = fu_data[ord[j]*XLEN +: XLEN];
                sbq.push_back(ne);
            end
            if (g > 0) m_rr = (ord[g-1] + 1) % NF;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_cnt", 64'(fifo_cnt), 64'd0);
        check_val("rst_wra_en", 64'(wra_en), 64'd0);
        check_val("rst_wrb_en", 64'(wrb_en), 64'd0);

        // single result, one-cycle latency to port A
        load_fu(0);
        fu_pdest[IDXW-1:0] = 6'd5;
        fu_data[XLEN-1:0]  = 64'hAA;
        fu_valid = 4'b0001;
        #1;
        check_val("t1_ready", 64'(fu_ready), 64'h1);
        step(4'b0001, 1'b0, 1'b0);
        fu_valid = 4'b0000;
        #1;
        check_val("t1_wra_en", 64'(wra_en), 64'd1);
        check_val("t1_wra_idx", 64'(wra_idx), 64'd5);
        check_val("t1_wra_data", wra_data, 64'hAA);
        check_val("t1_wrb_en", 64'(wrb_en), 64'd0);
        step(4'b0000, 1'b0, 1'b0);

        // all FUs valid: pairs granted in rotation, FIFO never exceeds two
        step(4'b0000, 1'b0, 1'b1);
        load_fu(0);
        fu_valid = 4'b1111;
        #1;
        check_val("t2_first_grant", 64'(fu_ready), 64'h3);
        for (int c = 0; c < 8; c++) begin
            load_fu(0);
            step(4'b1111, 1'b0, 1'b0);
            check_val("t2_cnt_le2", 64'(fifo_cnt <= 4'd2), 64'd1);
        end
        step(4'b0000, 1'b0, 1'b0);

        // hold fills the FIFO, then release drains two per cycle in order
        step(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            load_fu(0);
            step((c % 2 == 1) ? 4'b1100 : 4'b0011, 1'b1, 1'b0);
        end
        check_val("t3_full", 64'(fifo_cnt), 64'd8);
        step(4'b0000, 1'b0, 1'b0);
        check_val("t3_after_drain", 64'(fifo_cnt), 64'd6);
        repeat (4) step(4'b0000, 1'b0, 1'b0);

        // same-pdest pair issues on port A in two consecutive cycles
        step(4'b0000, 1'b0, 1'b1);
        load_fu(0);
        fu_pdest[IDXW-1:0]        = 6'd9;
        fu_data[XLEN-1:0]         = 64'h1;
        fu_pdest[2*IDXW-1:IDXW]   = 6'd9;
        fu_data[2*XLEN-1:XLEN]    = 64'h2;
        step(4'b0011, 1'b0, 1'b0);
        fu_valid = 4'b0000;
        #1;
        check_val("t4_k_idx", 64'(wra_idx), 64'd9);
        check_val("t4_k_data", wra_data, 64'h1);
        check_val("t4_k_wrb_en", 64'(wrb_en), 64'd0);
        step(4'b0000, 1'b0, 1'b0);
        #1;
        check_val("t4_k1_en", 64'(wra_en), 64'd1);
        check_val("t4_k1_data", wra_data, 64'h2);
        step(4'b0000, 1'b0, 1'b0);

        // one free slot: exactly one grant, nearest to the pointer
        step(4'b0000, 1'b0, 1'b1);
        load_fu(0); step(4'b0011, 1'b1, 1'b0);
        load_fu(0); step(4'b1100, 1'b1, 1'b0);
        load_fu(0); step(4'b0011, 1'b1, 1'b0);
        load_fu(0); step(4'b0001, 1'b1, 1'b0);
        check_val("t5_cnt7", 64'(fifo_cnt), 64'd7);
        load_fu(0);
        fu_valid = 4'b1011;
        wb_hold  = 1'b1;
        #1;
        check_val("t5_one_grant", 64'(fu_ready), 64'h2);
        step(4'b1011, 1'b1, 1'b0);
        load_fu(0);
        step(4'b1111, 1'b0, 1'b0);
        repeat (5) step(4'b0000, 1'b0, 1'b0);

        // reset with occupied FIFO discards everything
        load_fu(0); step(4'b0011, 1'b1, 1'b0);
        load_fu(0); step(4'b1100, 1'b1, 1'b0);
        load_fu(0); step(4'b0001, 1'b1, 1'b0);
        check_val("t6_cnt5", 64'(fifo_cnt), 64'd5);
        step(4'b0000, 1'b0, 1'b1);
        fu_valid = 4'b1111;
        wb_hold  = 1'b0;
        #1;
        check_val("t6_cnt0", 64'(fifo_cnt), 64'd0);
        check_val("t6_wra_en", 64'(wra_en), 64'd0);
        check_val("t6_wrb_en", 64'(wrb_en), 64'd0);
        check_val("t6_rr0", 64'(fu_ready), 64'h3);

        // random traffic with pdest collisions, holds and occasional resets
        for (int c = 0; c < 400; c++) begin
            load_fu(1);
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
        end
        repeat (8) step(4'b0000, 1'b0, 1'b0);
        check_val("final_empty", 64'(fifo_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
